polvecp2bs: RTL and testbench

- Packs a polynomial vector of 10-bit coefficients (SABER p-domain, 3x256 coeffs) into a byte string.
- Input memory holds 4 coefficients per 64-bit word, one in each 16-bit lane; output memory receives the dense 10-bit-packed stream at 120 x 64-bit words.
- Sits upstream of the byte-string-to-polynomial unpacker, which reads this packed layout back. It is the exact inverse, so a round-trip through both must be lossless.

---
 rtl/polvecp2bs.sv | 112 +++++++++++
 tb/tb_polvecp2bs.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/polvecp2bs.sv
// Packs 3x256 10-bit coefficients (one per 16-bit lane, four lanes per input word)
// into a dense little-endian bit stream written out as 64-bit words.
module polvecp2bs #(
  parameter int NUM_OUT_WORDS = 120,
  parameter int READ_BASE     = 0,
  parameter int WRITE_BASE    = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [8:0]  read_address,
  input  logic [63:0] read_data,
  output logic [8:0]  write_address,
  output logic [63:0] write_data,
  output logic        write_en,
  output logic        done
);

  localparam logic [8:0] RD_BASE = 9'(READ_BASE);
  localparam logic [8:0] WR_BASE = 9'(WRITE_BASE);
  localparam logic [8:0] WR_LAST = 9'(WRITE_BASE + NUM_OUT_WORDS - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_F0, S_F1, S_F2, S_F3, S_F4, S_F5, S_F6, S_F7, S_F8,
    S_W0, S_W1, S_W2, S_W3, S_W4, S_DONE
  } state_t;

  state_t       state_q, state_d;
  logic [8:0]   read_addr_q, read_addr_d;
  logic [8:0]   write_addr_q, write_addr_d;
  logic [319:0] buffer_q, buffer_d;
  logic         load_en, fetch_en, capture_en, write_act;

  // Only the low 10 bits of each 16-bit lane carry a coefficient.
  logic [39:0] chunk;
  logic [23:0] unused_lane_bits;
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign chunk[gi*10 +: 10]           = read_data[gi*16 +: 10];
    assign unused_lane_bits[gi*6 +: 6]  = read_data[gi*16+10 +: 6];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: if (start) state_d = S_F0;
      S_F8:           state_d = S_W0;
      S_W4:           state_d = (write_addr_q == WR_LAST) ? S_DONE : S_F0;
      default:        state_d = state_t'(state_q + 4'd1);
    endcase
  end

  always_comb begin
    load_en    = 1'b0;
    fetch_en   = 1'b0;
    capture_en = 1'b0;
    write_act  = 1'b0;
    done       = 1'b0;
    case (state_q)
      S_IDLE:                         load_en = start;
      S_DONE:                         begin load_en = start; done = 1'b1; end
      S_F0:                           fetch_en = 1'b1;
      S_F1, S_F2, S_F3, S_F4,
      S_F5, S_F6, S_F7:               begin fetch_en = 1'b1; capture_en = 1'b1; end
      S_F8:                           capture_en = 1'b1;
      S_W0, S_W1, S_W2, S_W3, S_W4:   write_act = 1'b1;
      default:                        ;
    endcase
  end

  // Capture of the previous address's data overlaps issuing the next address.
  always_comb begin
    read_addr_d  = read_addr_q;
    write_addr_d = write_addr_q;
    buffer_d     = buffer_q;
    if (load_en) begin
      read_addr_d  = RD_BASE;
      write_addr_d = WR_BASE;
    end
    if (fetch_en) read_addr_d = read_addr_q + 9'd1;
    if (capture_en) buffer_d = {chunk, buffer_q[319:40]};
    if (write_act) begin
      buffer_d     = {64'd0, buffer_q[319:64]};
      write_addr_d = write_addr_q + 9'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      read_addr_q  <= RD_BASE;
      write_addr_q <= WR_BASE;
      buffer_q     <= '0;
    end else begin
      read_addr_q  <= read_addr_d;
      write_addr_q <= write_addr_d;
      buffer_q     <= buffer_d;
    end
  end

  assign read_address  = read_addr_q;
  assign write_address = write_addr_q;
  assign write_data    = buffer_q[63:0];
  assign write_en      = write_act;

endmodule

// File: tb/tb_polvecp2bs.sv
// Scoreboard bench for polvecp2bs: a bit-stream reference model queues expected writes,
// a negedge monitor compares them, and directed runs probe timing, reset and rerun.
module tb_polvecp2bs;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start;
  logic [8:0]  read_address, write_address;
  logic [63:0] read_data, write_data;
  logic        write_en, done;

  logic        rst5, start5;
  logic [8:0]  ra5, wa5;
  logic [63:0] rd5, wd5;
  logic        we5, done5;

  logic [63:0] in_mem  [0:511];
  logic [63:0] out_mem [0:511];
  logic [63:0] out5_mem [0:7];

  polvecp2bs dut (
    .clk(clk), .rst(rst), .start(start),
    .read_address(read_address), .read_data(read_data),
    .write_address(write_address), .write_data(write_data),
    .write_en(write_en), .done(done)
  );

  polvecp2bs #(.NUM_OUT_WORDS(5)) dut5 (
    .clk(clk), .rst(rst5), .start(start5),
    .read_address(ra5), .read_data(rd5),
    .write_address(wa5), .write_data(wd5),
    .write_en(we5), .done(done5)
  );

  always @(posedge clk) read_data <= in_mem[read_address];
  always @(posedge clk) if (write_en) out_mem[write_address] <= write_data;
  always @(posedge clk) rd5 <= in_mem[ra5];
  always @(posedge clk) if (we5) out5_mem[wa5[2:0]] <= wd5;

  typedef struct {
    logic [8:0]  addr;
    logic [63:0] data;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  int we5_cnt = 0;

  always @(posedge clk) if (we5) we5_cnt <= we5_cnt + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Coefficient n of the vector is lane n%4 of input word n/4; the stream is their
  // concatenation at 10 bits each, little-endian.
  function automatic logic [63:0] model_word(input int m);
    logic [63:0] w;
    int idx, n, k;
    for (int b = 0; b < 64; b++) begin
      idx  = 64 * m + b;
      n    = idx / 10;
      k    = idx % 10;
      w[b] = in_mem[n / 4][(n % 4) * 16 + k];
    end
    return w;
  endfunction

  always @(negedge clk) begin
    if (rst && write_en) begin
      wr_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write actual=addr %0d data %h required=no write", write_address, write_data);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("write_addr", {55'd0, write_address}, {55'd0, e.addr});
        chk("write_data", write_data, e.data);
        $display("write addr=%0d data=%h", write_address, write_data);
      end
    end
  end

  task automatic fill_mem(input int mode);
    logic [63:0] w;
    for (int i = 0; i < 512; i++) begin
      w = '0;
      case (mode)
        0: for (int j = 0; j < 4; j++) w[16*j +: 16] = 16'((4 * i + j) % 1024);
        1: w = 64'h03FF_03FF_03FF_03FF;
        2: w = 64'hFC00_FC00_FC00_FC00;
        default: w = {$urandom, $urandom};
      endcase
      in_mem[i] = w;
    end
  endtask

  // One packing run; inject pulses start during F3 and W1, abort_at>0 resets at that edge.
  task automatic do_run(input string tag, input bit inject, input int abort_at);
    int done_c, wr0;
    exp_t e;
    for (int m = 0; m < 120; m++) begin
      e.addr = 9'(m);
      e.data = model_word(m);
      exp_q.push_back(e);
    end
    wr0 = wr_cnt;
    done_c = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, "_done_after_start"}, {63'd0, done}, 64'd0);
    for (int c = 1; c <= 400; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (done) begin
        done_c = c;
        break;
      end
      if (c == abort_at) begin
        chk({tag, "_we_before_abort"}, {63'd0, write_en}, 64'd1);
        rst = 1'b0;
        @(posedge clk); #1;
        chk({tag, "_abort_we"}, {63'd0, write_en}, 64'd0);
        chk({tag, "_abort_done"}, {63'd0, done}, 64'd0);
        chk({tag, "_abort_raddr"}, {55'd0, read_address}, 64'd0);
        chk({tag, "_abort_waddr"}, {55'd0, write_address}, 64'd0);
        rst = 1'b1;
        exp_q.delete();
        $display("run %s aborted at edge %0d", tag, c);
        return;
      end
      if (inject && (c == 3 || c == 10)) start = 1'b1;
    end
    chk({tag, "_done_edge"}, 64'(done_c), 64'd336);
    chk({tag, "_end_raddr"}, {55'd0, read_address}, 64'd192);
    chk({tag, "_end_waddr"}, {55'd0, write_address}, 64'd120);
    chk({tag, "_write_count"}, 64'(wr_cnt - wr0), 64'd120);
    chk({tag, "_queue_left"}, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    $display("run %s done at edge %0d", tag, done_c);
  endtask

  initial begin
    logic [63:0] acc;
    logic [39:0] got, want;
    int n, bit_idx, d5;
    rst = 1'b0; start = 1'b0; rst5 = 1'b0; start5 = 1'b0;
    fill_mem(0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_raddr", {55'd0, read_address}, 64'd0);
    chk("rst_waddr", {55'd0, write_address}, 64'd0);
    chk("rst_we", {63'd0, write_en}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    do_run("ramp", 1'b0, 0);
    chk("ramp_word0", out_mem[0], 64'h6014_0400_C020_0400);

    fill_mem(1);
    do_run("ones", 1'b0, 0);
    acc = '1;
    for (int m = 0; m < 120; m++) acc &= out_mem[m];
    chk("ones_all", acc, 64'hFFFF_FFFF_FFFF_FFFF);

    fill_mem(2);
    do_run("junk", 1'b0, 0);
    acc = '0;
    for (int m = 0; m < 120; m++) acc |= out_mem[m];
    chk("junk_all", acc, 64'd0);

    fill_mem(3);
    do_run("rand_inject", 1'b1, 0);
    for (int i = 0; i < 192; i++) begin
      for (int j = 0; j < 4; j++) begin
        n = 4 * i + j;
        for (int k = 0; k < 10; k++) begin
          bit_idx = 10 * n + k;
          got[10*j + k] = out_mem[bit_idx / 64][bit_idx % 64];
        end
        want[10*j +: 10] = in_mem[i][16*j +: 10];
      end
      chk("roundtrip", {24'd0, got}, {24'd0, want});
    end

    fill_mem(3);
    do_run("abort", 1'b0, 81);
    do_run("after_abort", 1'b0, 0);
    do_run("rerun_from_done", 1'b0, 0);

    rst5 = 1'b1;
    @(posedge clk); #1;
    start5 = 1'b1;
    @(posedge clk); #1;
    start5 = 1'b0;
    d5 = 0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (done5) begin
        d5 = c;
        break;
      end
    end
    chk("n5_done_edge", 64'(d5), 64'd14);
    chk("n5_raddr", {55'd0, ra5}, 64'd8);
    chk("n5_waddr", {55'd0, wa5}, 64'd5);
    chk("n5_writes", 64'(we5_cnt), 64'd5);
    for (int m = 0; m < 5; m++) chk("n5_word", out5_mem[m], model_word(m));
    $display("run n5 done at edge %0d", d5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
